// File: rtl/param_rotate_align.sv
// param_rotate_align
//   Sequential inverse of the parameterized rotator. Given a reference word
//   and a rotated word, it tries one left-rotate amount per cycle and reports
//   the smallest matching amount. The result uses the rotator's amt/op
//   encoding (op=0 left, op=1 right), so it can drive a rotator directly to
//   re-align data.
//
//   Build option: define ROTALIGN_EARLY_EXIT_EN to leave the search on the
//   first match (latency k+1). Without it, every search scans all nbits
//   candidates (latency constant nbits). Result values match in both builds.
//
// Ports
//   clk      in   clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   in_val   in   request valid
//   in_rdy   out  request ready (IDLE only)
//   in_      in   [nbits]  rotated word (search target)
//   ref_     in   [nbits]  reference (unrotated) word
//   out_val  out  result valid (DONE only)
//   out_rdy  in   result ready
//   found    out  1 = some rotation matches
//   amt      out  [$clog2(nbits)] rotation amount
//   op       out  0 = rotate left, 1 = rotate right
module param_rotate_align #(
  parameter int nbits = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_val,
  output logic                     in_rdy,
  input  logic [nbits-1:0]         in_,
  input  logic [nbits-1:0]         ref_,
  output logic                     out_val,
  input  logic                     out_rdy,
  output logic                     found,
  output logic [$clog2(nbits)-1:0] amt,
  output logic                     op
);

  localparam int AW = $clog2(nbits);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SEARCH = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  localparam logic [AW-1:0] LAST = AW'(nbits - 1);
  localparam logic [AW-1:0] HALF = AW'(nbits / 2);

`ifdef ROTALIGN_EARLY_EXIT_EN
  localparam logic EARLY = 1'b1;
`else
  localparam logic EARLY = 1'b0;
`endif

  logic [1:0]         r_state;
  logic [AW-1:0]      r_cnt;
  logic [nbits-1:0]   r_in;
  logic [nbits-1:0]   r_ref;
  logic               r_found;
  logic [AW-1:0]      r_amt;
  logic               r_op;

  logic [2*nbits-1:0] w_dbl;
  logic [nbits-1:0]   w_rot;
  logic               w_hit;
  logic [AW-1:0]      w_neg;

  // Left rotate: the upper half of {ref,ref} shifted left by cnt.
  assign w_dbl = {r_ref, r_ref} << r_cnt;
  assign w_rot = w_dbl[2*nbits-1:nbits];

  // Only the first match counts; later matches never overwrite it.
  assign w_hit = (w_rot == r_in) && !r_found;

  // nbits - cnt, taken modulo 2^AW (nbits is a power of two).
  assign w_neg = AW'(0) - r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_in    <= '0;
      r_ref   <= '0;
      r_found <= 1'b0;
      r_amt   <= '0;
      r_op    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_val) begin
            r_in    <= in_;
            r_ref   <= ref_;
            r_cnt   <= '0;
            r_found <= 1'b0;
            r_amt   <= '0;
            r_op    <= 1'b0;
            r_state <= SEARCH;
          end
        end
        SEARCH: begin
          if (w_hit) begin
            r_found <= 1'b1;
            // A tie at nbits/2 stays a left rotate.
            if (r_cnt > HALF) begin
              r_op  <= 1'b1;
              r_amt <= w_neg;
            end else begin
              r_op  <= 1'b0;
              r_amt <= r_cnt;
            end
          end
          if ((r_cnt == LAST) || (EARLY && w_hit))
            r_state <= DONE;
          else
            r_cnt <= r_cnt + 1'b1;
        end
        DONE: begin
          if (out_rdy) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_rdy  = (r_state == IDLE);
  assign out_val = (r_state == DONE);
  assign found   = r_found;
  assign amt     = r_amt;
  assign op      = r_op;

endmodule

// File: tb/tb_param_rotate_align.sv
// Self-checking bench for param_rotate_align (nbits=8): directed cases,
// randomized requests against a reference model, backpressure and a reset
// pulse in the middle of a search.
module tb_param_rotate_align;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       in_val;
  logic       in_rdy;
  logic [7:0] in_;
  logic [7:0] ref_;
  logic       out_val;
  logic       out_rdy;
  logic       found;
  logic [2:0] amt;
  logic       op;

  int n_chk = 0;
  int n_err = 0;

  param_rotate_align #(.nbits(N)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_val(in_val), .in_rdy(in_rdy), .in_(in_), .ref_(ref_),
    .out_val(out_val), .out_rdy(out_rdy),
    .found(found), .amt(amt), .op(op)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Smallest left-rotate amount k with rotl(r,k)==d, then mapped to the
  // shorter direction (tie goes left).
  task automatic model(input int r, input int d, output int f, output int a,
                       output int o, output int lat);
    int k;
    k = -1;
    for (int i = 0; i < N; i++) begin
      int rot;
      rot = ((r << i) | (r >> (N - i))) & 'hFF;
      if (k < 0 && rot == d) k = i;
    end
    f = (k >= 0);
    a = 0; o = 0;
    if (k > N / 2) begin o = 1; a = N - k; end
    else if (k >= 0) a = k;
`ifdef ROTALIGN_EARLY_EXIT_EN
    lat = (k >= 0) ? k + 1 : N;
`else
    lat = N;
`endif
  endtask

  // Called #1 after a rising edge. Issues one request, measures latency,
  // holds the result under backpressure for 'hold' cycles, then drains it.
  task automatic run(input logic [7:0] r, input logic [7:0] d, input int hold);
    int ef, ea, eo, el, lat;
    model(r, d, ef, ea, eo, el);
    chk("in_rdy_idle", in_rdy, 1);
    ref_ = r; in_ = d; in_val = 1'b1;
    @(posedge clk); #1;
    in_val = 1'b0;
    // Scramble inputs: they must only be sampled at the accept edge.
    ref_ = 8'($urandom); in_ = 8'($urandom);
    lat = 0;
    while (!out_val && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, el);
    chk("found", found, ef);
    chk("amt", amt, ea);
    chk("op", op, eo);
    for (int c = 0; c < hold; c++) begin
      @(posedge clk); #1;
      chk("hold_val", out_val, 1);
      chk("hold_rdy", in_rdy, 0);
      chk("hold_res", {found, amt, op}, {ef[0], ea[2:0], eo[0]});
    end
    out_rdy = 1'b1;
    @(posedge clk); #1;
    out_rdy = 1'b0;
    chk("drain_val", out_val, 0);
    chk("drain_rdy", in_rdy, 1);
  endtask

  initial begin
    reset_n = 1'b0; in_val = 1'b0; out_rdy = 1'b0; in_ = '0; ref_ = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_val", out_val, 0);
    chk("rst_res", {found, amt, op}, 0);
    reset_n = 1'b1;
    #1;
    chk("rst_in_rdy", in_rdy, 1);
    @(posedge clk); #1;

    // Directed cases
    run(8'h81, 8'h03, 0);
    run(8'h01, 8'h80, 0);
    run(8'h0F, 8'hF0, 0);
    run(8'hAA, 8'h55, 0);
    run(8'h01, 8'h03, 0);
    run(8'h5A, 8'h5A, 0);
    run(8'h81, 8'h03, 5);

    // Reset pulse in the middle of a search aborts it
    ref_ = 8'h01; in_ = 8'h80; in_val = 1'b1;
    @(posedge clk); #1;
    in_val = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #2;
    chk("midrst_val", out_val, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    #1;
    chk("post_rst_val", out_val, 0);
    chk("post_rst_rdy", in_rdy, 1);
    chk("post_rst_found", found, 0);
    begin
      int seen = 0;
      repeat (12) begin
        @(posedge clk); #1;
        if (out_val) seen = 1;
      end
      chk("no_result_after_rst", seen, 0);
    end
    run(8'h0F, 8'hF0, 2);

    // Randomized requests: half are true rotations, half arbitrary words
    for (int t = 0; t < 40; t++) begin
      logic [7:0] r, d;
      int k;
      r = 8'($urandom);
      k = $urandom_range(0, N - 1);
      if (t % 2 == 0) d = 8'((({8'h00, r} << k) | (r >> (N - k))) & 16'h00FF);
      else            d = 8'($urandom);
      run(r, d, $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/param_rotate_align.md
Name: param_rotate_align

Overview:
- Sequential inverse of the parameterized rotator: given a reference word and a rotated word, it searches for the rotation amount and direction that map the reference onto the rotated word.
- Result is encoded in the same amt/op convention the rotator consumes (op=0 left, op=1 right), so it can drive a rotator to re-align data.
- Sits in front of alignment/unrotate paths.
- Uses val/rdy on input and output; checks one candidate rotation per cycle.

Parameters:
- nbits, 8, word width; power of two, >= 2; amt width is $clog2(nbits).

Ports:
- clk  input  1  clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_val  input  1  request valid.
- in_rdy  output  1  request ready.
- in_  input  nbits  rotated word (search target).
- ref_  input  nbits  reference (unrotated) word.
- out_val  output  1  result valid.
- out_rdy  input  1  result ready.
- found  output  1  1 = a rotation matches.
- amt  output  $clog2(nbits)  rotation amount.
- op  output  1  0 = rotate left, 1 = rotate right.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, cnt=0, captured regs=0.
  - in_rdy=1 once released.
  - out_val=0, found=0, amt=0, op=0.
  - Reset asserted mid-search aborts the search; no result is produced.
- States IDLE, SEARCH, DONE; in_rdy=1 only in IDLE; out_val=1 only in DONE.
- IDLE:
  - On the edge with in_val&&in_rdy, capture in_ and ref_, cnt<=0, go to SEARCH.
  - in_/ref_ are sampled only at that edge.
- SEARCH, each cycle:
  - Compare rotl(ref_reg, cnt) against in_reg; rotl is a left rotate, MSBs wrapping to LSBs.
  - On the first match, record k=cnt and set the found flag. A later match never overwrites an earlier one.
  - If cnt==nbits-1, go to DONE. Otherwise cnt<=cnt+1; cnt never wraps.
  - Early exit: see Optional Feature.
- Result encoding (k = smallest matching left-rotate amount):
  - k <= nbits/2: op=0, amt=k. A tie at nbits/2 is reported as left.
  - k > nbits/2: op=1, amt=nbits-k.
  - No match: found=0, amt=0, op=0.
  - ref_==in_: found=1, amt=0, op=0.
- DONE:
  - out_val=1; found/amt/op held stable until out_rdy=1.
  - On the edge with out_val&&out_rdy, go to IDLE.
  - No same-cycle re-accept: in_rdy is 0 in DONE.
- Latency, measured in edges from the accepting edge until out_val rises:
  - Without early exit: always nbits.
  - With early exit and a match at k: k+1.
  - With early exit and no match: nbits.
- Throughput: at most one request in flight.
- Outputs are registered; no combinational path from in_* to out_*.

Optional Feature:
- Macro: ROTALIGN_EARLY_EXIT_EN.
- Defined: SEARCH leaves for DONE on the cycle a match is found. Latency is data-dependent (k+1).
- Undefined: the search always scans all nbits candidates. Latency is a constant nbits, for fixed-schedule pipelines.
- The result values are identical in both builds.

Test Plan (nbits=8):
- ref_=0x81, in_=0x03 -> found=1, op=0, amt=1. out_val rises 2 edges after accept with EARLY_EXIT, 8 without.
- ref_=0x01, in_=0x80 (k=7) -> found=1, op=1, amt=1.
- ref_=0x0F, in_=0xF0 (k=4 tie) -> found=1, op=0, amt=4.
- ref_=0xAA, in_=0x55 (matches at k=1,3,5,7) -> smallest wins: op=0, amt=1.
- ref_=0x01, in_=0x03 -> found=0, amt=0, op=0; latency 8 in both builds.
- Backpressure/reset:
  - Hold out_rdy=0 for 5 cycles -> outputs stable, in_rdy=0.
  - Then pulse reset_n low mid-SEARCH of a new request -> out_val=0 and in_rdy=1 immediately after release; the next request is processed correctly.
